// File: rtl/pixel_unpacker_if.sv
// Byte-stream input and frame-buffer write side of pixel_unpacker.
// The slave modport is the unpacker; the master modport is whatever feeds it.
interface pixel_unpacker_if #(
   parameter int ADDR_W = 15
);
   logic [7:0]        data_in;
   logic              data_valid;
   logic              image_start;
   logic              image_end;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [1:0]        wr_data;
   logic              chunk_done;
   logic              image_complete;
   logic              busy;
   logic              overflow_err;
   logic              length_err;

   modport master (
      output data_in, data_valid, image_start, image_end,
      input  wr_en, wr_addr, wr_data, chunk_done, image_complete, busy,
             overflow_err, length_err
   );

   modport slave (
      input  data_in, data_valid, image_start, image_end,
      output wr_en, wr_addr, wr_data, chunk_done, image_complete, busy,
             overflow_err, length_err
   );
endinterface

// File: rtl/pixel_unpacker.sv
// Buffers received bytes in a small FIFO and unpacks each into four 2-bit
// palette writes with a linear frame-buffer address; tracks chunks and errors.
module pixel_unpacker #(
   parameter int ADDR_W      = 15,
   parameter int PIXELS      = 32768,
   parameter int CHUNK_BYTES = 256,
   parameter int FIFO_DEPTH  = 4
) (
   input logic             clk,
   input logic             reset,
   pixel_unpacker_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BC_W  = $clog2(CHUNK_BYTES + 1);

   typedef enum logic [1:0] {IDLE, RECEIVE, DRAIN, DONE} state_t;
   state_t state_q, state_d;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wptr, rptr;
   logic [CNT_W-1:0]  count;
   logic              fifo_empty, fifo_full, push_req, push, pop;

   logic              active;
   logic [1:0]        phase;
   logic [7:0]        shreg;
   logic [1:0]        issue_bits;
   logic              issue, pixel_ok;
   logic [ADDR_W:0]   pix_cnt;
   logic [BC_W-1:0]   byte_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_en_p1, chunk_p1, ovf_q, len_q;
   logic [1:0]        wr_data_p1;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign push_req   = bus.data_valid && (state_q == RECEIVE) && !bus.image_start;
   assign pop        = !active && !fifo_empty && !bus.image_start;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push       = push_req && (!fifo_full || pop);
   assign issue      = pop || active;
   assign pixel_ok   = (pix_cnt < (ADDR_W+1)'(PIXELS));

   always_comb begin
      issue_bits = mem[rptr][7:6];
      if (active) begin
         case (phase)
            2'd1:    issue_bits = shreg[5:4];
            2'd2:    issue_bits = shreg[3:2];
            default: issue_bits = shreg[1:0];
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.image_start) begin
         state_d = RECEIVE;
      end else begin
         case (state_q)
            RECEIVE: if (bus.image_end) state_d = DRAIN;
            DRAIN:   if (fifo_empty && !active) state_d = DONE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= bus.data_in;
   end

   // Stage p1: one write issued per cycle, popped byte's first write in the pop cycle.
   always_ff @(posedge clk) begin
      if (reset || bus.image_start) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         active     <= 1'b0;
         phase      <= '0;
         pix_cnt    <= '0;
         byte_cnt   <= '0;
         addr_q     <= '0;
         wr_en_p1   <= 1'b0;
         chunk_p1   <= 1'b0;
         ovf_q      <= 1'b0;
         len_q      <= 1'b0;
         if (reset) wr_data_p1 <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (push_req && !push) ovf_q <= 1'b1;

         wr_en_p1 <= 1'b0;
         chunk_p1 <= 1'b0;
         if (wr_en_p1 && addr_q != ADDR_W'(PIXELS - 1)) addr_q <= addr_q + 1'b1;

         if (issue) begin
            if (pixel_ok) begin
               wr_en_p1   <= 1'b1;
               wr_data_p1 <= issue_bits;
               pix_cnt    <= pix_cnt + 1'b1;
            end else begin
               len_q <= 1'b1;
            end
            if (pop) begin
               shreg  <= mem[rptr];
               active <= 1'b1;
               phase  <= 2'd1;
            end else begin
               phase <= phase + 2'd1;
               if (phase == 2'd3) begin
                  active <= 1'b0;
                  if (byte_cnt == BC_W'(CHUNK_BYTES - 1)) begin
                     byte_cnt <= '0;
                     chunk_p1 <= 1'b1;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
         end

         if (state_q == DRAIN && state_d == DONE && pix_cnt != (ADDR_W+1)'(PIXELS))
            len_q <= 1'b1;
      end
   end

   assign bus.wr_en          = wr_en_p1;
   assign bus.wr_addr        = addr_q;
   assign bus.wr_data        = wr_data_p1;
   assign bus.chunk_done     = chunk_p1;
   assign bus.overflow_err   = ovf_q;
   assign bus.length_err     = len_q;
   assign bus.busy           = (state_q == RECEIVE) || (state_q == DRAIN);
   assign bus.image_complete = (state_q == DONE);
endmodule

// File: tb/tb_pixel_unpacker.sv
// Scoreboard bench for pixel_unpacker: expected writes are queued as bytes are
// accepted and popped by a negedge monitor whenever wr_en is seen.
module tb_pixel_unpacker;
   localparam int ADDR_W      = 15;
   localparam int PIXELS      = 32768;
   localparam int CHUNK_BYTES = 256;
   localparam int FIFO_DEPTH  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pixel_unpacker_if #(.ADDR_W(ADDR_W)) bus ();

   pixel_unpacker #(
      .ADDR_W(ADDR_W), .PIXELS(PIXELS), .CHUNK_BYTES(CHUNK_BYTES), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [1:0]        data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  errors = 0, checks = 0;
   int  exp_pix = 0, wr_cnt = 0, chunk_cnt = 0, last_addr = -1;

   logic [ADDR_W+7:0] outs;
   assign outs = {bus.wr_en, bus.wr_addr, bus.wr_data, bus.chunk_done, bus.image_complete,
                  bus.busy, bus.overflow_err, bus.length_err};

   always @(negedge clk) begin
      if (!reset && bus.wr_en === 1'b1) begin
         wr_cnt++;
         last_addr = int'(bus.wr_addr);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                     bus.wr_addr, bus.wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.wr_addr, bus.wr_data} !== mon_e) begin
               errors++;
               $display("FAIL write: got addr %0d data %0d, required addr %0d data %0d",
                        bus.wr_addr, bus.wr_data, mon_e.addr, mon_e.data);
            end
         end
      end
      if (!reset && bus.chunk_done === 1'b1) begin
         chunk_cnt++;
         checks++;
         if (!(bus.wr_en === 1'b1 && bus.wr_addr[9:0] === 10'h3ff)) begin
            errors++;
            $display("FAIL chunk_align: got wr_en %0b addr %0d, required wr_en 1 at last pixel of a chunk",
                     bus.wr_en, bus.wr_addr);
         end
      end
   end

   task automatic push_expected(input logic [7:0] b);
      for (int k = 0; k < 4; k++) begin
         if (exp_pix < PIXELS) exp_q.push_back({ADDR_W'(exp_pix), 2'(b >> (6 - 2*k))});
         exp_pix++;
      end
   endtask

   task automatic put_byte(input logic [7:0] b, input bit accept);
      bus.data_in    = b;
      bus.data_valid = 1'b1;
      if (accept) push_expected(b);
      @(posedge clk); #1;
      bus.data_valid = 1'b0;
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         put_byte(8'($urandom_range(0, 255)), 1'b1);
         repeat (3) @(posedge clk);
         #1;
      end
   endtask

   task automatic burst7();
      for (int i = 0; i < 7; i++) begin
         bus.data_in    = 8'hA0 + 8'(i);
         bus.data_valid = 1'b1;
         if (i < 6) push_expected(bus.data_in);
         @(posedge clk); #1;
      end
      bus.data_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
   endtask

   task automatic start_image();
      bus.image_start = 1'b1;
      @(posedge clk); #1;
      bus.image_start = 1'b0;
      exp_pix = 0; wr_cnt = 0; chunk_cnt = 0; last_addr = -1;
   endtask

   task automatic pulse_end();
      bus.image_end = 1'b1;
      @(posedge clk); #1;
      bus.image_end = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      @(negedge clk);
      while (bus.image_complete !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.image_complete !== 1'b1) begin
         errors++;
         $display("FAIL drain_timeout: image_complete=%0b after %0d cycles, required 1",
                  bus.image_complete, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required 0", outs);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      bus.image_end = 1'b1;
      put_byte(8'hFF, 1'b0);
      bus.image_end = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.image_complete, bus.wr_en} !== 3'b000) begin
         errors++;
         $display("FAIL idle_ignore: got busy/complete/wr_en %b, required 000",
                  {bus.busy, bus.image_complete, bus.wr_en});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_byte();
      start_image();
      bus.data_in    = 8'hE4;
      bus.data_valid = 1'b1;
      push_expected(8'hE4);
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.busy} !== 2'b01) begin
         errors++;
         $display("FAIL latency_n: got wr_en/busy %b, required 01", {bus.wr_en, bus.busy});
      end
      @(posedge clk); #1;
      bus.data_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.wr_en !== 1'b0) begin
         errors++;
         $display("FAIL latency_n1: got wr_en %0b, required 0", bus.wr_en);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, ADDR_W'(k), 2'(3 - k)}) begin
            errors++;
            $display("FAIL e4_write%0d: got en %0b addr %0d data %0d, required en 1 addr %0d data %0d",
                     k, bus.wr_en, bus.wr_addr, bus.wr_data, k, 3 - k);
         end
      end
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b0, ADDR_W'(4), 2'd0}) begin
         errors++;
         $display("FAIL e4_hold: got en %0b addr %0d data %0d, required en 0 addr 4 data 0",
                  bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      @(posedge clk); #1;
      pulse_end();
      wait_done(20);
      checks++;
      if ({bus.length_err, bus.overflow_err, bus.busy} !== 3'b100) begin
         errors++;
         $display("FAIL e4_close: got len/ovf/busy %b, required 100",
                  {bus.length_err, bus.overflow_err, bus.busy});
      end
   endtask

   task automatic test_full_image();
      start_image();
      stream(8192);
      pulse_end();
      wait_done(64);
      checks++;
      if (wr_cnt !== 32768 || chunk_cnt !== 32 || last_addr !== 32767 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL full_counts: got writes %0d chunks %0d last %0d pending %0d, required 32768 32 32767 0",
                  wr_cnt, chunk_cnt, last_addr, exp_q.size());
      end
      checks++;
      if ({bus.wr_addr, bus.length_err, bus.overflow_err} !== {ADDR_W'(32767), 2'b00}) begin
         errors++;
         $display("FAIL full_flags: got addr %0d len %0b ovf %0b, required 32767 0 0",
                  bus.wr_addr, bus.length_err, bus.overflow_err);
      end
   endtask

   task automatic test_short_image();
      start_image();
      stream(99);
      bus.image_end = 1'b1;
      put_byte(8'h3C, 1'b1);
      bus.image_end = 1'b0;
      wait_done(64);
      checks++;
      if (wr_cnt !== 400 || chunk_cnt !== 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL short_counts: got writes %0d chunks %0d pending %0d, required 400 0 0",
                  wr_cnt, chunk_cnt, exp_q.size());
      end
      checks++;
      if ({bus.length_err, bus.overflow_err} !== 2'b10) begin
         errors++;
         $display("FAIL short_flags: got len/ovf %b, required 10", {bus.length_err, bus.overflow_err});
      end
      put_byte(8'h55, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (wr_cnt !== 400 || bus.image_complete !== 1'b1) begin
         errors++;
         $display("FAIL done_ignore: got writes %0d complete %0b, required 400 1",
                  wr_cnt, bus.image_complete);
      end
   endtask

   task automatic test_long_image();
      start_image();
      stream(8193);
      checks++;
      if (wr_cnt !== 32768 || last_addr !== 32767 || bus.wr_addr !== ADDR_W'(32767)) begin
         errors++;
         $display("FAIL long_nowrap: got writes %0d last %0d addr %0d, required 32768 32767 32767",
                  wr_cnt, last_addr, bus.wr_addr);
      end
      checks++;
      if ({bus.length_err, bus.busy} !== 2'b11) begin
         errors++;
         $display("FAIL long_err: got len/busy %b, required 11", {bus.length_err, bus.busy});
      end
      pulse_end();
      wait_done(64);
      checks++;
      if (exp_q.size() != 0 || wr_cnt !== 32768) begin
         errors++;
         $display("FAIL long_drain: got pending %0d writes %0d, required 0 32768", exp_q.size(), wr_cnt);
      end
   endtask

   task automatic test_overflow();
      start_image();
      burst7();
      checks++;
      if (bus.overflow_err !== 1'b1 || wr_cnt !== 24 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL overflow: got ovf %0b writes %0d pending %0d, required 1 24 0",
                  bus.overflow_err, wr_cnt, exp_q.size());
      end
   endtask

   task automatic test_abort();
      int n = 0;
      start_image();
      burst7();
      stream(4);
      exp_q.push_back({ADDR_W'(40), 2'd2});
      exp_q.push_back({ADDR_W'(41), 2'd1});
      exp_q.push_back({ADDR_W'(42), 2'd3});
      put_byte(8'h9C, 1'b0);
      @(negedge clk);
      while (!(bus.wr_en === 1'b1 && bus.wr_addr === ADDR_W'(41)) && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!(bus.wr_en === 1'b1 && bus.wr_addr === ADDR_W'(41))) begin
         errors++;
         $display("FAIL abort_wait: got en %0b addr %0d, required en 1 addr 41", bus.wr_en, bus.wr_addr);
      end
      @(posedge clk); #1;
      bus.image_start = 1'b1;
      @(posedge clk); #1;
      bus.image_start = 1'b0;
      exp_pix = 0; wr_cnt = 0; chunk_cnt = 0;
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.wr_addr, bus.overflow_err, bus.length_err, bus.busy, bus.image_complete}
          !== {1'b0, ADDR_W'(0), 4'b0010}) begin
         errors++;
         $display("FAIL abort_clear: got en %0b addr %0d ovf %0b len %0b busy %0b cmp %0b, required 0 0 0 0 1 0",
                  bus.wr_en, bus.wr_addr, bus.overflow_err, bus.length_err, bus.busy, bus.image_complete);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL abort_pending: got %0d writes outstanding, required 0", exp_q.size());
      end
      @(posedge clk); #1;
      put_byte(8'h1B, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (wr_cnt !== 4 || last_addr !== 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL abort_restart: got writes %0d last %0d pending %0d, required 4 3 0",
                  wr_cnt, last_addr, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      start_image();
      burst7();
      put_byte(8'hC3, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.busy, bus.overflow_err} !== 3'b111) begin
         errors++;
         $display("FAIL mid_state: got en/busy/ovf %b, required 111",
                  {bus.wr_en, bus.busy, bus.overflow_err});
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_mid: got %h, required 0", outs);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      #1_500_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      bus.data_in     = '0;
      bus.data_valid  = 1'b0;
      bus.image_start = 1'b0;
      bus.image_end   = 1'b0;
      test_reset();
      test_single_byte();
      test_full_image();
      test_short_image();
      test_long_image();
      test_overflow();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
